// File: rtl/sev_seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver: shadows a packed hex value and scans
// one digit per refresh period. Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module sev_seg_scan_driver #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  output logic [6:0]              ca,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    digit_tick
);

  localparam int unsigned IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PrescW = $clog2(REFRESH_DIV);

  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [PrescW-1:0]       presc_q, presc_d;
  logic [IdxW-1:0]         index_q, index_d;
  logic                    tick_q, tick_d;
  logic [6:0]              ca_q, ca_d;
  logic                    dp_out_q, dp_out_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic                    wrap;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_en;
  logic                    blank;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    unique case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

  // Shadow capture, prescaler and scan index.
  always_comb begin
    value_d = load ? value : value_q;
    dp_d    = load ? dp_in : dp_q;
    wrap    = (presc_q == PrescW'(REFRESH_DIV - 1));
    presc_d = wrap ? '0 : presc_q + 1'b1;
    tick_d  = wrap;
    index_d = index_q;
    if (wrap) begin
      if (index_q == IdxW'(NUM_DIGITS - 1)) begin
        index_d = '0;
      end else begin
        index_d = index_q + 1'b1;
      end
    end
  end

  // Select the scanned digit's nibble, dp request and live enable.
  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_en  = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (index_q == IdxW'(i)) begin
        cur_nib = value_q[4*i +: 4];
        cur_dp  = dp_q[i];
        cur_en  = digit_en[i];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] zero_from;

  // zero_from[i]: nibbles i..NUM_DIGITS-1 of the shadow are all zero.
  always_comb begin
    zero_from = '0;
    zero_from[NUM_DIGITS-1] = (value_q[4*NUM_DIGITS-1 -: 4] == 4'h0);
    for (int i = int'(NUM_DIGITS) - 2; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] && (value_q[4*i +: 4] == 4'h0);
    end
    blank = 1'b0;
    for (int i = 1; i < int'(NUM_DIGITS); i++) begin
      if (index_q == IdxW'(i)) begin
        blank = zero_from[i];
      end
    end
  end
`else
  assign blank = 1'b0;
`endif

  // Registered output stage; a disabled digit keeps its slot with all anodes off.
  always_comb begin
    an_d = '1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (index_q == IdxW'(i) && cur_en) begin
        an_d[i] = 1'b0;
      end
    end
    ca_d     = blank ? 7'b1111111 : hex_to_seg(cur_nib);
    dp_out_d = ~cur_dp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q  <= '0;
      dp_q     <= '0;
      presc_q  <= '0;
      index_q  <= '0;
      tick_q   <= 1'b0;
      ca_q     <= 7'b1111111;
      dp_out_q <= 1'b1;
      an_q     <= '1;
    end else begin
      value_q  <= value_d;
      dp_q     <= dp_d;
      presc_q  <= presc_d;
      index_q  <= index_d;
      tick_q   <= tick_d;
      ca_q     <= ca_d;
      dp_out_q <= dp_out_d;
      an_q     <= an_d;
    end
  end

  assign ca         = ca_q;
  assign dp         = dp_out_q;
  assign an         = an_q;
  assign digit_tick = tick_q;

endmodule

// File: doc/sev_seg_scan_driver.md
# sev_seg_scan_driver

Time-multiplexed driver for a common-anode multi-digit seven-segment display, successor to the single-digit hex decoder. Captures a packed hex value, scans one digit per refresh period, and drives the shared active-low segment bus, the decimal point and per-digit active-low anodes. It sits between the square-root result path and the board display pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- REFRESH_DIV, 100000, clk cycles each digit is lit; legal range >= 2.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- value  in  4*NUM_DIGITS  packed hex digits; nibble i ([4i+3:4i]) drives digit i; digit 0 is least significant.
- dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
- digit_en  in  NUM_DIGITS  per-digit enable, 1 = digit may light; sampled live, not captured.
- load  in  1  single-cycle strobe; captures value and dp_in into shadow registers.
- ca  out  7  segments {a,b,c,d,e,f,g}, ca[6] = a, active low.
- dp  out  1  decimal point, active low.
- an  out  NUM_DIGITS  anode selects, active low; at most one bit low at any time.
- digit_tick  out  1  one-cycle pulse when the scan index advances.

## Operation
- Hex encoding of ca, digits 0..F in order: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
- Shadow registers: value_q and dp_q. They load on any cycle with load = 1 and hold otherwise. The display always shows shadow content, never live value.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. On wrap, scan index increments, NUM_DIGITS-1 wraps to 0, and digit_tick is 1 for that cycle.
- Output stage is registered from (index, value_q, dp_q, digit_en):
  - an = ~(1 << index) when digit_en[index] = 1, else all ones.
  - ca = encode(value_q nibble[index]).
  - dp = ~dp_q[index].
- A disabled digit keeps its time slot, so duty cycle is constant at 1/NUM_DIGITS. During that slot an is all ones; ca and dp still follow the normal rule.
- Reset values: an all ones, ca = 1111111, dp = 1, digit_tick = 0, index = 0, prescaler = 0, value_q = 0, dp_q = 0.
- Reset mid-scan: all of the above values apply on the next edge with rst = 1, with no partial-slot carryover.
- NUM_DIGITS = 1: index stays at 0. digit_tick still pulses every REFRESH_DIV cycles.

## Timing
- load to ca/dp: load sampled at edge N updates the shadows at N; outputs reflect the new data at edge N+1, if that digit is being scanned.
- Index advance: the prescaler wrap at edge N updates the index at N; an, ca and dp for the new digit appear at edge N+1. digit_tick is high during the cycle after edge N.
- First digit after reset: rst low at edge R gives an[0] = 0 (if digit_en[0] = 1) from edge R+1. The first advance occurs REFRESH_DIV cycles after reset release.
- load coincident with an index advance: both take effect. Edge N+1 shows the new digit with the new shadow data.
- digit_en change: takes effect on an at the next edge, with no slot realignment.

## Configuration
- LEADING_ZERO_BLANK_EN defined: digit i (i >= 1) is blanked when nibbles i..NUM_DIGITS-1 of value_q are all zero.
  - A blanked digit gets ca = 1111111; an and dp behave normally.
  - Digit 0 is never blanked.
  - Blanking is evaluated on shadow data in the same registered stage, so latency is unchanged.
- Undefined: all enabled digits show their hex glyph, including leading zeros.

## Test plan
All scenarios use NUM_DIGITS = 4 and REFRESH_DIV = 4.
- Reset: hold rst 3 cycles mid-scan -> an = 1111, ca = 1111111, dp = 1, digit_tick = 0; after release, an = 1110 one cycle later and digit_tick first pulses 4 cycles after release.
- Scan order: load value = 16'h1A3F, dp_in = 0100, digit_en = 1111 -> slots show an/ca: 1110/0111000, 1101/0000110, 1011/0001000 with dp = 0, 0111/1001111; sequence repeats every 16 cycles.
- Load coherency: change value to 16'h0000 without load -> display unchanged; pulse load -> new ca two edges after load assertion.
- Simultaneous events: load on the prescaler wrap cycle -> next digit shows new data in the first cycle of its slot.
- Digit enable: digit_en = 1010 -> an = 1111 during slots 0 and 2, and digit_tick period stays 4 cycles.
- LEADING_ZERO_BLANK_EN: value = 16'h0050 -> digits 3 and 2 show ca = 1111111, digit 1 shows 0100100, digit 0 shows 0000001; value = 0 -> only digit 0 shows 0000001. Without the macro, all four glyphs are shown.
